// File: rtl/fifo_rd_stream.sv
// Turns a 1-cycle-latency FIFO read port (rd_en/valid) into a valid/ready stream using a
// 2-entry in-order skid buffer. Optional transfer counter: define FIFO_RD_STREAM_XFER_CNT_EN.
module fifo_rd_stream #(
   parameter int unsigned DATA_WIDTH = 1024,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_valid,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  ovf_err,
   output logic [CNT_WIDTH-1:0]  xfer_cnt
);

   logic [1:0]            count_q, count_d;
   logic                  head_q, head_d;
   logic                  tail_q, tail_d;
   logic                  inflight_q;
   logic                  ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0] mem_q [2];

   logic       pop;
   logic       push;
   logic       full;
   logic [2:0] occ;

   assign m_valid = (count_q != 2'd0);
   assign m_data  = mem_q[head_q];
   assign ovf_err = ovf_q;

   assign pop  = m_valid & m_ready;
   assign full = (count_q == 2'd2);
   // A word arriving on a full buffer is only acceptable if a slot frees up this cycle.
   assign push = fifo_valid & (~full | pop);

   // Occupancy the buffer will have to absorb once the outstanding read lands.
   assign occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_rd_en = rst_n & ~fifo_empty & (occ < 3'd2);

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      ovf_d   = ovf_q;
      if (push) begin
         tail_d = ~tail_q;
      end
      if (pop) begin
         head_d = ~head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (fifo_valid && full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= 2'd0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         inflight_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         inflight_q <= fifo_rd_en;
         ovf_q      <= ovf_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else if (push) begin
         mem_q[tail_q] <= fifo_rd_data;
      end
   end

`ifdef FIFO_RD_STREAM_XFER_CNT_EN
   logic [CNT_WIDTH-1:0] xfer_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt_q <= '0;
      end else if (pop) begin
         xfer_cnt_q <= xfer_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign xfer_cnt = xfer_cnt_q;
`else
   assign xfer_cnt = '0;
`endif

endmodule
